// File: rtl/pulse_spacer.sv
// -----------------------------------------------------------------------------
// pulse_spacer
//
// Source-domain pacing stage that sits directly upstream of a single-cycle
// pulse clock-domain crosser. Bursty single-cycle event strobes are counted in
// a saturating backlog. They are re-emitted one at a time as registered
// single-cycle pulses. Consecutive pulses are at least GAP_CYCLES clocks apart,
// so the crosser only ever sees sparse pulses. Events that arrive while the
// backlog is full are dropped, and the sticky overflow flag records the drop.
//
// Parameters
//   GAP_CYCLES     minimum distance in clk cycles between pulse_out
//                  assertions (legal range >= 2)
//   PENDING_WIDTH  backlog counter width; max backlog = 2**PENDING_WIDTH - 1
//
// Ports
//   clk        in   source-domain clock, the only clock
//   reset      in   asynchronous, active-high reset
//   event_in   in   single-cycle event strobe; each high cycle is one event
//   clear      in   synchronous flush of backlog and overflow flag
//   pulse_out  out  registered single-cycle pulse to the crosser
//   pending    out  events accepted but not yet emitted
//   busy       out  cooldown running or backlog non-empty
//   overflow   out  sticky: an event was dropped because the backlog was full
//   dbg_in_gap out  FSM state for observation (1 = GAP, 0 = IDLE)
//
// Handshake: there is no backpressure anywhere. event_in is a fire-and-forget
// strobe. Every high cycle is accepted into the backlog or, when the backlog
// is full, dropped and flagged. pulse_out is likewise a strobe, and the
// downstream crosser must take each pulse.
// -----------------------------------------------------------------------------
module pulse_spacer #(
   parameter int GAP_CYCLES    = 8,
   parameter int PENDING_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     event_in,
   input  logic                     clear,
   output logic                     pulse_out,
   output logic [PENDING_WIDTH-1:0] pending,
   output logic                     busy,
   output logic                     overflow,
   output logic                     dbg_in_gap
);

   // Cooldown down-counter: it holds GAP_CYCLES-1 in the pulse cycle and
   // reaches 0 in the last cooldown cycle. That last cycle is the one in
   // which the next emit may be decided.
   localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0]         CD_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]         CD_ZERO  = '0;
   localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
   localparam logic [PENDING_WIDTH-1:0] PEND_ONE = PENDING_WIDTH'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cd_q, cd_d;
   logic [PENDING_WIDTH-1:0]   pending_q, pending_d;
   logic                       pulse_q, pulse_d;
   logic                       overflow_q, overflow_d;

   logic                       ready;
   logic                       emit;

   // Ready: no cooldown, or this is the last cooldown cycle. An emit decided
   // now shows up on pulse_out exactly GAP_CYCLES after the previous pulse.
   assign ready = (state_q == ST_IDLE) || (cd_q == CD_ZERO);

   // clear suppresses the emit, and it also discards the event on its cycle.
   assign emit  = ready && !clear && ((pending_q != '0) || event_in);

   always_comb begin
      state_d    = state_q;
      cd_d       = cd_q;
      pending_d  = pending_q;
      pulse_d    = 1'b0;
      overflow_d = overflow_q;

      // Backlog and overflow flag.
      if (clear) begin
         pending_d  = '0;
         overflow_d = 1'b0;
      end else if (emit) begin
         pulse_d = 1'b1;
         // An arriving event replaces the one being emitted, so the net
         // change is zero. This holds even when the backlog is full.
         if (!event_in) begin
            pending_d = pending_q - PEND_ONE;
         end
      end else if (event_in) begin
         if (pending_q == PEND_MAX) begin
            overflow_d = 1'b1;
         end else begin
            pending_d = pending_q + PEND_ONE;
         end
      end

      // Cooldown FSM. clear does not touch the cooldown, so the spacing to
      // the previous pulse is kept.
      case (state_q)
         ST_IDLE: begin
            cd_d = CD_ZERO;
            if (emit) begin
               state_d = ST_GAP;
               cd_d    = CD_LOAD;
            end
         end
         ST_GAP: begin
            if (emit) begin
               cd_d = CD_LOAD;
            end else if (cd_q == CD_ZERO) begin
               state_d = ST_IDLE;
            end else begin
               cd_d = cd_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cd_d    = CD_ZERO;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cd_q       <= CD_ZERO;
         pending_q  <= '0;
         pulse_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cd_q       <= cd_d;
         pending_q  <= pending_d;
         pulse_q    <= pulse_d;
         overflow_q <= overflow_d;
      end
   end

   assign pulse_out  = pulse_q;
   assign pending    = pending_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q == ST_GAP) || (pending_q != '0);
   assign dbg_in_gap = (state_q == ST_GAP);

   // A pulse is always followed by a cooldown, so two back-to-back pulses
   // are impossible.
   a_no_double_pulse : assert property (
      @(posedge clk) disable iff (reset) pulse_q |=> !pulse_q
   );

   // While the cooldown is running the FSM must be in GAP.
   a_cd_only_in_gap : assert property (
      @(posedge clk) disable iff (reset) (state_q == ST_IDLE) |-> (cd_q == CD_ZERO)
   );

endmodule
